// File: rtl/fpu_pkg.sv
// Shared FPU definitions: op encoding, default mantissa width, result record.
package fpu_pkg;

  localparam logic FPU_OP_ADD = 1'b0;
  localparam logic FPU_OP_SUB = 1'b1;

  // Mantissa width including the hidden bit (single precision).
  localparam int unsigned SIZE_MAN_DEF = 24;

  typedef struct packed {
    logic [SIZE_MAN_DEF-1:0] man;
    logic                    overflow;
    logic                    neg;
    logic                    zero;
  } fpu_res_t;

endpackage

// File: rtl/cla_nbit.sv
// Width-parametrised carry-lookahead adder: 4-bit lookahead groups with
// group generate/propagate feeding the inter-group carry chain.
module cla_nbit #(
  parameter int unsigned W = 24
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  localparam int unsigned NB = (W + 3) / 4;

  logic [W-1:0]  g;
  logic [W-1:0]  p;
  logic [W-1:0]  c;
  logic [NB-1:0] gg;
  logic [NB-1:0] pp;
  logic [NB-1:0] cg;

  assign g = a & b;
  assign p = a ^ b;

  // Group generate/propagate over each 4-bit slice (last slice may be partial).
  always_comb begin
    gg = '0;
    pp = '1;
    for (int unsigned i = 0; i < W; i++) begin
      gg[i/4] = g[i] | (p[i] & gg[i/4]);
      pp[i/4] = pp[i/4] & p[i];
    end
  end

  // Carry into each group from the group lookahead terms.
  always_comb begin
    cg    = '0;
    cg[0] = cin;
    for (int unsigned k = 1; k < NB; k++) begin
      cg[k] = gg[k-1] | (pp[k-1] & cg[k-1]);
    end
  end

  // Per-bit carries inside each group, seeded by that group's carry-in.
  always_comb begin
    logic t;
    t = 1'b0;
    c = '0;
    for (int unsigned i = 0; i < W; i++) begin
      if (i % 4 == 0) t = cg[i/4];
      c[i] = t;
      t    = g[i] | (p[i] & t);
    end
  end

  assign sum  = p ^ c;
  assign cout = gg[NB-1] | (pp[NB-1] & cg[NB-1]);

endmodule

// File: rtl/add_sub_man_alu_pipe.sv
// Pipelined mantissa add/sub ALU for the FPU add/sub path: signed sum or
// magnitude of difference with negative/overflow/zero flags, zero-operand
// bypass, valid/ready handshake and a pass-through tag.
module add_sub_man_alu_pipe
  import fpu_pkg::*;
#(
  parameter int unsigned SIZE_MAN  = SIZE_MAN_DEF,
  parameter int unsigned NUM_STAGE = 2,
  parameter int unsigned SIZE_TAG  = 4
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_valid,
  output logic                o_ready,
  input  logic                i_fpu_op,
  input  logic                i_sign_a,
  input  logic                i_sign_b,
  input  logic                i_borrow,
  input  logic                i_E_zero_A,
  input  logic                i_E_zero_B,
  input  logic [SIZE_MAN-1:0] i_man_max,
  input  logic [SIZE_MAN-1:0] i_man_min,
  input  logic [SIZE_TAG-1:0] i_tag,
  output logic                o_valid,
  input  logic                i_ready,
  output logic [SIZE_MAN-1:0] o_man_alu,
  output logic                o_overflow,
  output logic                o_neg,
  output logic                o_zero,
  output logic [SIZE_TAG-1:0] o_tag
);

  // Front end: decode straight from the inputs.
  logic f_eff_sub, f_za, f_zb, f_cin;

  assign f_eff_sub = (i_fpu_op == FPU_OP_SUB) ^ i_sign_a ^ i_sign_b;
  assign f_za      = i_E_zero_A & ~|i_man_max[SIZE_MAN-2:0];
  assign f_zb      = i_E_zero_B & ~|i_man_min[SIZE_MAN-2:0];
  assign f_cin     = f_eff_sub & ~i_borrow;

  // Back end operands: either the stage-1 registers or the front end directly.
  logic                x_eff_sub, x_za, x_zb, x_cin;
  logic [SIZE_MAN-1:0] x_max, x_min;

  logic [SIZE_MAN-1:0] add_b, add_s, neg_mag;
  logic                add_c;

  assign add_b = x_eff_sub ? ~x_min : x_min;

  cla_nbit #(.W(SIZE_MAN)) u_cla (
    .a    (x_max),
    .b    (add_b),
    .cin  (x_cin),
    .sum  (add_s),
    .cout (add_c)
  );

  assign neg_mag = ~add_s + SIZE_MAN'(1);

  logic [SIZE_MAN-1:0] r_man;
  logic                r_ov, r_neg, r_zero;

  // Result select. On subtract the adder carry-out is the inverted sign of
  // the SIZE_MAN+1-bit difference, so no extra bit of adder is needed.
  always_comb begin
    r_man = add_s;
    r_ov  = 1'b0;
    r_neg = 1'b0;
    if (x_za) begin
      r_man = x_min;
    end else if (x_zb) begin
      r_man = x_max;
    end else if (x_eff_sub) begin
      r_neg = ~add_c;
      if (!add_c) r_man = neg_mag;
    end else begin
      r_ov = add_c;
    end
    r_zero = (r_man == '0);
  end

  if (NUM_STAGE == 2) begin : g_two
    logic                v1, s1_eff_sub, s1_za, s1_zb, s1_cin;
    logic [SIZE_MAN-1:0] s1_max, s1_min;
    logic [SIZE_TAG-1:0] s1_tag;
    logic                adv2;

    assign adv2    = ~o_valid | i_ready;
    assign o_ready = ~v1 | adv2;

    assign x_eff_sub = s1_eff_sub;
    assign x_za      = s1_za;
    assign x_zb      = s1_zb;
    assign x_cin     = s1_cin;
    assign x_max     = s1_max;
    assign x_min     = s1_min;

    // Stage 1: capture decoded operands whenever the stage can advance.
    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        v1         <= 1'b0;
        s1_eff_sub <= 1'b0;
        s1_za      <= 1'b0;
        s1_zb      <= 1'b0;
        s1_cin     <= 1'b0;
        s1_max     <= '0;
        s1_min     <= '0;
        s1_tag     <= '0;
      end else if (o_ready) begin
        v1 <= i_valid;
        if (i_valid) begin
          s1_eff_sub <= f_eff_sub;
          s1_za      <= f_za;
          s1_zb      <= f_zb;
          s1_cin     <= f_cin;
          s1_max     <= i_man_max;
          s1_min     <= i_man_min;
          s1_tag     <= i_tag;
        end
      end
    end

    // Stage 2: register the arithmetic result; held while downstream stalls.
    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        o_valid    <= 1'b0;
        o_man_alu  <= '0;
        o_overflow <= 1'b0;
        o_neg      <= 1'b0;
        o_zero     <= 1'b0;
        o_tag      <= '0;
      end else if (adv2) begin
        o_valid <= v1;
        if (v1) begin
          o_man_alu  <= r_man;
          o_overflow <= r_ov;
          o_neg      <= r_neg;
          o_zero     <= r_zero;
          o_tag      <= s1_tag;
        end
      end
    end
  end else if (NUM_STAGE == 1) begin : g_one
    assign o_ready = ~o_valid | i_ready;

    assign x_eff_sub = f_eff_sub;
    assign x_za      = f_za;
    assign x_zb      = f_zb;
    assign x_cin     = f_cin;
    assign x_max     = i_man_max;
    assign x_min     = i_man_min;

    // Single stage: whole computation lands in the output register.
    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        o_valid    <= 1'b0;
        o_man_alu  <= '0;
        o_overflow <= 1'b0;
        o_neg      <= 1'b0;
        o_zero     <= 1'b0;
        o_tag      <= '0;
      end else if (o_ready) begin
        o_valid <= i_valid;
        if (i_valid) begin
          o_man_alu  <= r_man;
          o_overflow <= r_ov;
          o_neg      <= r_neg;
          o_zero     <= r_zero;
          o_tag      <= i_tag;
        end
      end
    end
  end else begin : g_bad
    $error("add_sub_man_alu_pipe: NUM_STAGE must be 1 or 2");
  end

endmodule

// File: tb/tb_add_sub_man_alu_pipe.sv
// Bench for add_sub_man_alu_pipe: a 2-stage and a 1-stage instance fed the
// same stream, each checked against an arithmetic reference and a queue.
module tb_add_sub_man_alu_pipe;
  import fpu_pkg::*;

  typedef struct packed {
    fpu_res_t   r;
    logic [3:0] tag;
  } exp_t;

  logic        clk, rst;
  logic        drv_valid, in_valid, rdy_in;
  logic        op, sa, sb, bor, eza, ezb;
  logic [23:0] mx, mn;
  logic [3:0]  tag;

  logic        ordy [2];
  logic        ovld [2];
  logic [23:0] oman [2];
  logic        oov  [2];
  logic        oneg [2];
  logic        ozero[2];
  logic [3:0]  otag [2];

  int   n_checks = 0;
  int   n_errors = 0;
  int   rdy_mode = 0;
  int   bp_cnt   = 0;
  exp_t q0[$];
  exp_t q1[$];
  logic        stalled[2];
  logic [30:0] prev   [2];

  assign in_valid = drv_valid & ordy[0] & ordy[1];

  add_sub_man_alu_pipe #(.SIZE_MAN(24), .NUM_STAGE(2), .SIZE_TAG(4)) dut2 (
    .i_clk(clk), .i_rst(rst), .i_valid(in_valid), .o_ready(ordy[0]),
    .i_fpu_op(op), .i_sign_a(sa), .i_sign_b(sb), .i_borrow(bor),
    .i_E_zero_A(eza), .i_E_zero_B(ezb), .i_man_max(mx), .i_man_min(mn),
    .i_tag(tag), .o_valid(ovld[0]), .i_ready(rdy_in), .o_man_alu(oman[0]),
    .o_overflow(oov[0]), .o_neg(oneg[0]), .o_zero(ozero[0]), .o_tag(otag[0])
  );

  add_sub_man_alu_pipe #(.SIZE_MAN(24), .NUM_STAGE(1), .SIZE_TAG(4)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_valid(in_valid), .o_ready(ordy[1]),
    .i_fpu_op(op), .i_sign_a(sa), .i_sign_b(sb), .i_borrow(bor),
    .i_E_zero_A(eza), .i_E_zero_B(ezb), .i_man_max(mx), .i_man_min(mn),
    .i_tag(tag), .o_valid(ovld[1]), .i_ready(rdy_in), .o_man_alu(oman[1]),
    .o_overflow(oov[1]), .o_neg(oneg[1]), .o_zero(ozero[1]), .o_tag(otag[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string nm);
    n_checks++;
    n_errors++;
    $display("FAIL %s: timeout waiting for DUT at %0t", nm, $time);
  endtask

  // Reference: plain integer arithmetic on the operand values.
  function automatic fpu_res_t model(input logic p_op, p_sa, p_sb, p_bor, p_eza, p_ezb,
                                     input logic [23:0] p_mx, p_mn);
    fpu_res_t r;
    longint   d;
    logic     eff;
    r   = '0;
    eff = (p_op == FPU_OP_SUB) ^ p_sa ^ p_sb;
    if (p_eza && p_mx[22:0] == 23'd0) begin
      r.man = p_mn;
    end else if (p_ezb && p_mn[22:0] == 23'd0) begin
      r.man = p_mx;
    end else if (eff) begin
      d = longint'(p_mx) - longint'(p_mn) - longint'(p_bor);
      if (d < 0) begin
        r.neg = 1'b1;
        d     = -d;
      end
      r.man = d[23:0];
    end else begin
      d          = longint'(p_mx) + longint'(p_mn);
      r.man      = d[23:0];
      r.overflow = d[24];
    end
    r.zero = (r.man == 24'd0);
    return r;
  endfunction

  task automatic check_dut(input int k);
    exp_t        q[$];
    logic [30:0] cur;
    int          depth;
    if (k == 0) q = q0; else q = q1;
    depth = (k == 0) ? 2 : 1;
    cur   = {oman[k], oov[k], oneg[k], ozero[k], otag[k]};
    chk($sformatf("ready_d%0d", k), ordy[k], (q.size() < depth) || rdy_in);
    if (stalled[k]) chk($sformatf("hold_d%0d", k), {ovld[k], cur}, {1'b1, prev[k]});
    if (ovld[k]) begin
      if (q.size() == 0) begin
        chk($sformatf("spurious_d%0d", k), ovld[k], 1'b0);
      end else begin
        chk($sformatf("result_d%0d_tag%0h", k, q[0].tag), cur, q[0]);
        if (rdy_in) void'(q.pop_front());
      end
    end
    stalled[k] = ovld[k] & ~rdy_in;
    prev[k]    = cur;
    if (k == 0) q0 = q; else q1 = q;
  endtask

  // Compare process: every falling edge, check both DUTs and log accepted inputs.
  initial begin
    stalled[0] = 1'b0;
    stalled[1] = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        for (int k = 0; k < 2; k++) begin
          chk($sformatf("rst_out_d%0d", k),
              {ovld[k], oman[k], oov[k], oneg[k], ozero[k], otag[k]}, 64'd0);
          stalled[k] = 1'b0;
        end
        q0.delete();
        q1.delete();
      end else begin
        check_dut(0);
        check_dut(1);
        if (in_valid) begin
          q0.push_back({model(op, sa, sb, bor, eza, ezb, mx, mn), tag});
          q1.push_back({model(op, sa, sb, bor, eza, ezb, mx, mn), tag});
        end
      end
    end
  end

  // Downstream ready: 0 = always ready, 1 = 1,0,0 pattern, 2 = random.
  initial begin
    rdy_in = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       rdy_in = 1'b1;
        1:       begin rdy_in = (bp_cnt % 3 == 0); bp_cnt++; end
        default: rdy_in = ($urandom_range(3) != 0);
      endcase
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send(input logic p_op, p_sa, p_sb, p_bor, p_eza, p_ezb,
                      input logic [23:0] p_mx, p_mn, input logic [3:0] p_tag);
    bit done;
    op = p_op; sa = p_sa; sb = p_sb; bor = p_bor; eza = p_eza; ezb = p_ezb;
    mx = p_mx; mn = p_mn; tag = p_tag;
    drv_valid = 1'b1;
    done = 1'b0;
    for (int k = 0; k < 100 && !done; k++) begin
      @(negedge clk);
      if (in_valid) begin
        @(posedge clk);
        #1;
        done = 1'b1;
      end
    end
    if (!done) timeout_fail("send");
    drv_valid = 1'b0;
  endtask

  // One operation into an empty pipe; checks latency and literal result.
  task automatic directed(input string nm, input logic p_op, p_sa, p_sb, p_bor, p_eza, p_ezb,
                          input logic [23:0] p_mx, p_mn, input logic [26:0] exp);
    int          lat  [2];
    logic [26:0] got  [2];
    bit          found[2];
    int          cyc;
    send(p_op, p_sa, p_sb, p_bor, p_eza, p_ezb, p_mx, p_mn, 4'hA);
    found[0] = 0; found[1] = 0; lat[0] = 0; lat[1] = 0; got[0] = '0; got[1] = '0;
    cyc = 1;
    while (!(found[0] && found[1]) && cyc < 10) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (!found[k] && ovld[k]) begin
          found[k] = 1;
          lat[k]   = cyc;
          got[k]   = {oman[k], oov[k], oneg[k], ozero[k]};
        end
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    for (int k = 0; k < 2; k++) begin
      if (!found[k]) timeout_fail({nm, "_wait"});
      else begin
        chk($sformatf("%s_lat_d%0d", nm, k), lat[k], (k == 0) ? 2 : 1);
        chk($sformatf("%s_d%0d", nm, k), got[k], exp);
      end
    end
  endtask

  task automatic drain(input string nm);
    for (int k = 0; k < 50 && (q0.size() != 0 || q1.size() != 0); k++) begin
      @(posedge clk);
      #1;
    end
    chk({nm, "_q2"}, q0.size(), 0);
    chk({nm, "_q1"}, q1.size(), 0);
  endtask

  initial begin
    rst = 1'b1; drv_valid = 1'b0;
    op = 0; sa = 0; sb = 0; bor = 0; eza = 0; ezb = 0; mx = '0; mn = '0; tag = '0;
    #1;
    for (int k = 0; k < 2; k++)
      chk($sformatf("reset_state_d%0d", k),
          {ovld[k], oman[k], oov[k], oneg[k], ozero[k], otag[k]}, 64'd0);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    chk("ready_after_reset", {ordy[0], ordy[1]}, 2'b11);

    // {man, overflow, neg, zero}
    directed("add_ovf",   0, 0, 0, 0, 0, 0, 24'h800000, 24'h800000, {24'h000000, 3'b101});
    directed("sub",       1, 0, 0, 0, 0, 0, 24'hC00000, 24'h800000, {24'h400000, 3'b000});
    directed("sub_borr",  1, 0, 0, 1, 0, 0, 24'hC00000, 24'h800000, {24'h3FFFFF, 3'b000});
    directed("sub_neg",   1, 0, 0, 0, 0, 0, 24'h800000, 24'hC00000, {24'h400000, 3'b010});
    directed("sub_eq",    1, 0, 0, 0, 0, 0, 24'hA00000, 24'hA00000, {24'h000000, 3'b001});
    directed("zero_a",    0, 0, 0, 0, 1, 0, 24'h000000, 24'h123456, {24'h123456, 3'b000});
    directed("zero_b",    0, 0, 0, 0, 0, 1, 24'hABCDEF, 24'h800000, {24'hABCDEF, 3'b000});
    directed("zero_both", 1, 0, 0, 0, 1, 1, 24'h800000, 24'h000000, {24'h000000, 3'b001});
    directed("add_borr",  0, 0, 0, 1, 0, 0, 24'h400001, 24'h000002, {24'h400003, 3'b000});
    directed("sign_sub",  0, 1, 0, 0, 0, 0, 24'hC00000, 24'h800000, {24'h400000, 3'b000});

    // Backpressure: tags 0..7 with ready toggling 1,0,0,...
    bp_cnt   = 0;
    rdy_mode = 1;
    for (int t = 0; t < 8; t++)
      send($urandom_range(1), $urandom_range(1), $urandom_range(1), $urandom_range(1),
           0, 0, 24'($urandom), 24'($urandom), 4'(t));
    rdy_mode = 0;
    drain("bp_drain");

    // Random traffic with random downstream stalls.
    rdy_mode = 2;
    for (int n = 0; n < 250; n++) begin
      logic [23:0] rmx, rmn;
      logic        reza, rezb;
      rmx  = 24'($urandom);
      rmn  = ($urandom_range(7) == 0) ? rmx : 24'($urandom);
      reza = ($urandom_range(7) == 0);
      rezb = ($urandom_range(7) == 0);
      if (reza && $urandom_range(1) == 1) rmx[22:0] = '0;
      if (rezb && $urandom_range(1) == 1) rmn[22:0] = '0;
      send($urandom_range(1), $urandom_range(1), $urandom_range(1), $urandom_range(1),
           reza, rezb, rmx, rmn, 4'($urandom));
      repeat ($urandom_range(2)) begin
        @(posedge clk);
        #1;
      end
    end
    rdy_mode = 0;
    drain("rand_drain");

    // Reset with two operations in flight.
    send(0, 0, 0, 0, 0, 0, 24'h111111, 24'h222222, 4'h1);
    send(1, 0, 0, 0, 0, 0, 24'h333333, 24'h111111, 4'h2);
    rst = 1'b1;
    #1;
    for (int k = 0; k < 2; k++)
      chk($sformatf("midop_rst_d%0d", k),
          {ovld[k], oman[k], oov[k], oneg[k], ozero[k], otag[k]}, 64'd0);
    @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    chk("ready_after_midop_rst", {ordy[0], ordy[1]}, 2'b11);
    directed("post_rst", 1, 0, 0, 0, 0, 0, 24'h900000, 24'h100001, {24'h7FFFFF, 3'b000});
    drain("final_drain");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
